// File: rtl/gpio_apb_arb_pkg.sv
// Shared definitions for the gpio0 APB sequencer: FSM encoding and the
// position of the non-secure bit within the APB protection field.
package gpio_apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int PROT_NS_BIT = 1;

endpackage

// File: rtl/gpio_apb_rr2.sv
// Two-way requester picker: round-robin on ties, or fixed priority to
// requester 0 when RR_EN is 0. The pointer moves on the update strobe.
module gpio_apb_rr2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       grant_id,
  output logic       any_req
);

  logic prio_r;  // requester favoured on the next tie

  // Favour the requester that was not served last.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prio_r <= 1'b0;
    end else if (upd) begin
      prio_r <= ~upd_id;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Winner selection.
  always_comb begin
    grant_id = 1'b0;
    if (req == 2'b11) begin
      if (RR_EN) begin
        grant_id = prio_r;
      end else begin
        grant_id = 1'b0;
      end
    end else begin
      grant_id = req[1];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/gpio_apb_arb.sv
// Two-requester APB sequencer and security gate in front of the gpio0 slave:
// arbitrates, runs the SETUP/ACCESS transfer and blocks non-secure accesses.
module gpio_apb_arb
  import gpio_apb_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          tipc_gpio0_trust,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_prot,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_prot,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          psel,
  output logic          penable,
  output logic [AW-1:0] paddr,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  output logic [2:0]    pprot,
  input  logic [DW-1:0] prdata
);

  state_e        state_r, state_nxt_s;
  logic          id_r;
  logic          grant_s, any_req_s, deny_s;
  logic [AW-1:0] win_addr_s;
  logic          win_write_s;
  logic [DW-1:0] win_wdata_s;
  logic [2:0]    win_prot_s;
  logic          fin_s, fin_id_s, fin_err_s;
  logic [DW-1:0] fin_rdata_s;
  logic          psel_r, penable_r, pwrite_r;
  logic [AW-1:0] paddr_r;
  logic [DW-1:0] pwdata_r;
  logic [2:0]    pprot_r;
  logic          m0_done_r, m0_err_r, m1_done_r, m1_err_r;
  logic [DW-1:0] m0_rdata_r, m1_rdata_r;

  gpio_apb_rr2 #(.RR_EN(RR_EN)) u_rr2 (
    .pclk     (pclk),
    .presetn  (presetn),
    .req      ({m1_req, m0_req}),
    .upd      (state_r == ST_DONE),
    .upd_id   (id_r),
    .grant_id (grant_s),
    .any_req  (any_req_s)
  );

  // Mux the winning requester's transfer attributes.
  always_comb begin
    win_addr_s  = m0_addr;
    win_write_s = m0_write;
    win_wdata_s = m0_wdata;
    win_prot_s  = m0_prot;
    if (grant_s) begin
      win_addr_s  = m1_addr;
      win_write_s = m1_write;
      win_wdata_s = m1_wdata;
      win_prot_s  = m1_prot;
    end else begin
      win_addr_s  = m0_addr;
      win_write_s = m0_write;
      win_wdata_s = m0_wdata;
      win_prot_s  = m0_prot;
    end
  end

  // Trust is sampled in the grant cycle only; later changes do not abort.
  assign deny_s = tipc_gpio0_trust & win_prot_s[PROT_NS_BIT];

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          if (deny_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SETUP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_nxt_s = ST_ACCESS;
      ST_ACCESS: state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Result that lands on the winner's port when entering DONE.
  always_comb begin
    fin_s       = 1'b0;
    fin_id_s    = id_r;
    fin_err_s   = 1'b0;
    fin_rdata_s = {DW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_req_s && deny_s) begin
          fin_s     = 1'b1;
          fin_id_s  = grant_s;
          fin_err_s = 1'b1;
        end else begin
          fin_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        fin_s = 1'b1;
        if (pwrite_r) begin
          fin_rdata_s = {DW{1'b0}};
        end else begin
          fin_rdata_s = prdata;
        end
      end
      default: fin_s = 1'b0;
    endcase
  end

  // State, winner id and APB master registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r   <= ST_IDLE;
      id_r      <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      paddr_r   <= {AW{1'b0}};
      pwrite_r  <= 1'b0;
      pwdata_r  <= {DW{1'b0}};
      pprot_r   <= 3'b000;
    end else begin
      state_r   <= state_nxt_s;
      psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable_r <= (state_nxt_s == ST_ACCESS);
      if (state_r == ST_IDLE && any_req_s) begin
        id_r <= grant_s;
      end else begin
        id_r <= id_r;
      end
      // Bus attributes only move for a transfer that reaches the slave.
      if (state_r == ST_IDLE && state_nxt_s == ST_SETUP) begin
        paddr_r  <= win_addr_s;
        pwrite_r <= win_write_s;
        pwdata_r <= win_wdata_s;
        pprot_r  <= win_prot_s;
      end else begin
        paddr_r  <= paddr_r;
        pwrite_r <= pwrite_r;
        pwdata_r <= pwdata_r;
        pprot_r  <= pprot_r;
      end
    end
  end

  // Per-requester completion pulse, error and sticky read data.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m0_done_r  <= 1'b0;
      m0_err_r   <= 1'b0;
      m0_rdata_r <= {DW{1'b0}};
      m1_done_r  <= 1'b0;
      m1_err_r   <= 1'b0;
      m1_rdata_r <= {DW{1'b0}};
    end else begin
      m0_done_r <= fin_s && !fin_id_s;
      m1_done_r <= fin_s && fin_id_s;
      if (fin_s && !fin_id_s) begin
        m0_err_r   <= fin_err_s;
        m0_rdata_r <= fin_rdata_s;
      end else begin
        m0_err_r   <= 1'b0;
        m0_rdata_r <= m0_rdata_r;
      end
      if (fin_s && fin_id_s) begin
        m1_err_r   <= fin_err_s;
        m1_rdata_r <= fin_rdata_s;
      end else begin
        m1_err_r   <= 1'b0;
        m1_rdata_r <= m1_rdata_r;
      end
    end
  end

  assign psel     = psel_r;
  assign penable  = penable_r;
  assign paddr    = paddr_r;
  assign pwrite   = pwrite_r;
  assign pwdata   = pwdata_r;
  assign pprot    = pprot_r;
  assign m0_done  = m0_done_r;
  assign m0_err   = m0_err_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_done  = m1_done_r;
  assign m1_err   = m1_err_r;
  assign m1_rdata = m1_rdata_r;

endmodule

// File: doc/gpio_apb_arb.md
Name: gpio_apb_arb

Overview:
- Two-requester APB sequencer and security gate in front of the gpio0 APB slave port (psel/penable/paddr/pwrite/pwdata/prdata, no pready).
- Requester 0 is the CPU-side APB bridge; requester 1 is the ETB/DMA-side register-access agent.
- Arbitrates between them (round-robin or fixed priority) and generates the 2-phase APB transfer.
- Blocks non-secure accesses while tipc_gpio0_trust is high.

Parameters:
- AW, 32, address width of requesters and APB master.
- DW, 32, data width.
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- tipc_gpio0_trust  in  1  1 = gpio0 is secure-only
- m0_req / m1_req  in  1  transfer request; held high until the matching done
- m0_addr / m1_addr  in  AW  address
- m0_write / m1_write  in  1  1 = write
- m0_wdata / m1_wdata  in  DW  write data
- m0_prot / m1_prot  in  3  APB protection; bit1 = 1 means non-secure
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with done; 1 = access denied
- m0_rdata / m1_rdata  out  DW  read data, valid with done
- psel  out  1  APB select to gpio0
- penable  out  1  APB enable
- paddr  out  AW  APB address
- pwrite  out  1  APB direction
- pwdata  out  DW  APB write data
- pprot  out  3  APB protection
- prdata  in  DW  APB read data from gpio0

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours requester 0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: select the winner.
  - RR_EN=1: on a tie, the requester not granted last wins.
  - RR_EN=0: requester 0 wins.
  - Latch winner id, addr, write, wdata, prot. Sample trust in the same cycle.
- Deny rule: trust=1 and prot[1]=1 → go to DONE with err=1. No APB activity; rdata=0; gpio0 sees no write.
- Otherwise → SETUP.
- SETUP: psel=1, penable=0; paddr/pwrite/pwdata/pprot driven from latched values. Next state ACCESS.
- ACCESS: psel=1, penable=1, same latched values. Capture prdata at the end of the cycle if the transfer is a read; writes give rdata=0. Next state DONE.
- DONE: psel=0, penable=0. Pulse winner done for one cycle with registered rdata/err. Update round-robin pointer to the winner. Next state IDLE.
- Latency from the req-sampled cycle to the done cycle:
  - Allowed access: 3 cycles (SETUP, ACCESS, DONE).
  - Denied access: 1 cycle.
- Back-to-back: minimum one IDLE cycle between transfers. Continuous requests from both sides alternate when RR_EN=1.
- The non-winning requester's done/err stay 0. Its request remains pending and is evaluated at the next IDLE.
- Requester inputs are ignored after latching; changes mid-transfer have no effect.
- A req dropped before done is a protocol violation. The transfer still completes and done still pulses.
- Trust changing mid-transfer does not abort an already-granted transfer.
- paddr/pwrite/pwdata/pprot hold their last values in IDLE/DONE. psel/penable are 0 outside SETUP/ACCESS.
- rdata outputs hold until that requester's next done.
- Asynchronous reset mid-transfer: psel/penable drop immediately; no done is generated.

Decomposition:
- Shared package gpio_apb_arb_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3) and the PROT_NS_BIT=1 constant.
- One sub-module, gpio_apb_rr2: 2-way round-robin picker with pointer register, update strobe, and RR_EN fixed-priority mode.
- FSM, latches, and the security check stay in the top.

Test Plan:
- Single read: m0 read 0x50 with prdata=0xA5A5_0001, trust=0.
  - SETUP then ACCESS at cycles +1/+2 with paddr=0x50, pwrite=0.
  - m0_done at +3 with m0_rdata=0xA5A5_0001, err=0.
- Single write: m1 write 0x00 data 0x0000_00FF.
  - pwdata=0xFF during SETUP and ACCESS; m1_done at +3; m1_rdata=0.
- Security deny: trust=1, m0 write with prot=3'b010.
  - psel never asserted; m0_done next cycle with m0_err=1, m0_rdata=0.
  - Repeat with prot=3'b000: normal 3-cycle transfer, err=0.
- Contention with RR_EN=1: m0_req and m1_req high together for 4 transfers.
  - Grant order m0, m1, m0, m1; each done pulse only on its own port.
  - With RR_EN=0, the order is m0, m0, ... while m0 is held.
- Reset during ACCESS: assert presetn=0.
  - psel/penable go to 0 immediately; no done.
  - After release, a pending m1_req completes normally.
- Mid-transfer changes: alter m0_addr/m0_wdata during SETUP.
  - APB keeps the latched values; the transfer completes with the original address.
